// File: rtl/updown_counter_display_pkg.sv
// rtl/updown_counter_display_pkg.sv - shared widths and 7-segment lookup for updown_counter_display
// Contents: COUNT_W, SEG_W, SEG_TABLE (active-high {g,f,e,d,c,b,a} patterns indexed by count).
package updown_counter_display_pkg;

  localparam int COUNT_W = 3;
  localparam int SEG_W   = 7;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}, bit0 = a.
  localparam logic [SEG_W-1:0] SEG_TABLE [0:(1<<COUNT_W)-1] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07   // 7
  };

endpackage

// File: rtl/updown_counter_display_seg7_decoder.sv
// rtl/updown_counter_display_seg7_decoder.sv - combinational 7-segment decoder for one digit
// Ports: count (in, COUNT_W) current digit value; lights (out, SEG_W) segment drive {g..a}.
// SEG_ACTIVE_LOW=1 drives a lit segment with 0 (common-anode digit).
module seg7_decoder
  import updown_counter_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [COUNT_W-1:0] count,
  output logic [SEG_W-1:0]   lights
);

  logic [SEG_W-1:0] pattern;

  assign pattern = SEG_TABLE[count];
  assign lights  = SEG_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/updown_counter_display.sv
// rtl/updown_counter_display.sv - 3-bit up/down counter driving one 7-segment digit
// Ports: clk (in) rising-edge clock; reset (in) async active-low reset;
//        enable (in) 1 = step each edge; dir (in) 1 = up, 0 = down;
//        count (out, 3) current value; lights (out, 7) segment drive {g..a}.
module updown_counter_display
  import updown_counter_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic [SEG_W-1:0]   lights
);

  // Natural 3-bit overflow/underflow gives the 7->0 and 0->7 wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      if (dir) count <= count + 3'd1;
      else     count <= count - 3'd1;
    end
  end

  seg7_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decoder (
    .count (count),
    .lights(lights)
  );

endmodule

// File: tb/tb_updown_counter_display.sv
// tb/tb_updown_counter_display.sv - self-checking bench for updown_counter_display
module tb_updown_counter_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       dir = 1'b1;
  logic [2:0] count_a, count_b;
  logic [6:0] lights_a, lights_b;

  int checks = 0;
  int fails  = 0;
  int model  = 0;
  bit live   = 1'b0;

  // Expected segment drive straight from the digit table.
  logic [6:0] hi_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
  logic [6:0] lo_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  int up_exp   [12] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};
  int down_exp [4]  = '{1, 0, 7, 6};
  int down_lit [4]  = '{'h79, 'h40, 'h78, 'h02};

  always #5 clk = ~clk;

  updown_counter_display dut_a (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .dir   (dir),
    .count (count_a),
    .lights(lights_a)
  );

  updown_counter_display #(.SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .dir   (dir),
    .count (count_b),
    .lights(lights_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: the value is an integer stepped modulo 8.
  always @(posedge clk or negedge reset) begin
    if (!reset)      model = 0;
    else if (enable) model = dir ? (model + 1) % 8 : (model + 7) % 8;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_count_a",  count_a,  model);
      chk("model_lights_a", lights_a, lo_tab[model]);
      chk("model_count_b",  count_b,  model);
      chk("model_lights_b", lights_b, hi_tab[model]);
    end
  end

  initial begin
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    dir    = 1'b1;
    live   = 1'b1;

    // Reset held with enable/dir active.
    repeat (4) begin
      tick();
      chk("reset_hold_count",  count_a,  0);
      chk("reset_hold_lights", lights_a, 'h40);
    end
    reset = 1'b1;

    // Up count with wrap, first step on the first edge after release.
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_count",  count_a,  up_exp[i]);
      chk("up_lights", lights_a, lo_tab[up_exp[i]]);
    end

    // Walk down to 2, then down through the wrap.
    dir = 1'b0;
    repeat (2) tick();
    chk("down_start", count_a, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("down_count",  count_a,  down_exp[i]);
      chk("down_lights", lights_a, down_lit[i]);
    end

    // Hold at 5.
    tick();
    chk("pre_hold", count_a, 5);
    enable = 1'b0;
    repeat (5) begin
      tick();
      chk("hold_count",  count_a,  5);
      chk("hold_lights", lights_a, 'h12);
    end
    enable = 1'b1;
    dir    = 1'b1;
    tick();
    chk("resume_count", count_a, 6);

    // Asynchronous reset pulse between edges.
    #1 reset = 1'b0;
    #1;
    chk("async_count",    count_a,  0);
    chk("async_lights",   lights_a, 'h40);
    chk("async_lights_b", lights_b, 'h3F);
    #1 reset = 1'b1;
    tick();
    chk("after_async", count_a, 1);

    // Active-high instance sweep 0..7 and wrap.
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("pol_sweep_0", lights_b, 'h3F);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("pol_count",  count_b,  i % 8);
      chk("pol_lights", lights_b, hi_tab[i % 8]);
    end

    live = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
